display_queue: RTL and testbench

- Buffered display port between the CPU output-write path and the two-digit 7-segment decoder.
- Captures 4-bit values written by the single-cycle CPU into a small FIFO.
- Presents one value at a time on `number`, holding each for at least DWELL clock cycles so fast back-to-back CPU writes stay human-visible.
- After the queue drains, the last value stays on the display.

---
 rtl/display_queue.sv | 139 +++++++++++++
 tb/tb_display_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/display_queue.sv
// Display FIFO between the CPU output-write path and the 7-segment decoder.
// Each popped value is shown for at least DWELL cycles; the last one stays up once drained.
module display_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DWELL = 50000000,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [3:0]    wdata,
    input  logic          clr,
    output logic [3:0]    number,
    output logic          valid,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
    localparam logic [DW-1:0] DwellMax = DW'(DWELL - 1);

    typedef enum logic [1:0] {StIdle, StShow, StHold} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    number_q, number_d;
    logic          valid_q, valid_d;
    logic          full_q, full_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [3:0]    mem_q [DEPTH];

    logic pop;
    logic push;
    logic dwell_done;

    assign dwell_done = (dwell_q == DwellMax);

    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        number_d = number_q;
        valid_d  = valid_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        pop      = 1'b0;
        push     = 1'b0;

        if (clr) begin
            state_d  = StIdle;
            dwell_d  = '0;
            number_d = '0;
            valid_d  = 1'b0;
            count_d  = '0;
            ovf_d    = 1'b0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            unique case (state_q)
                StIdle, StHold: pop = (count_q != '0);
                StShow:         pop = (count_q != '0) && dwell_done;
                default:        pop = 1'b0;
            endcase

            // A pop frees a slot in the same cycle, so a full queue can still accept.
            push = we && ((count_q != DepthC) || pop);

            if (pop) begin
                number_d = mem_q[rd_ptr_q];
                valid_d  = 1'b1;
                dwell_d  = '0;
                state_d  = StShow;
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else if (state_q == StShow) begin
                if (dwell_done) begin
                    state_d = StHold;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (we && !push) begin
                ovf_d = 1'b1;
            end

            count_d = count_q + CW'(push) - CW'(pop);
        end

        full_d = (count_d == DepthC);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            dwell_q  <= '0;
            number_q <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            number_q <= number_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign number   = number_q;
    assign valid    = valid_q;
    assign full     = full_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_display_queue.sv
// Randomized and directed bench for display_queue against a queue-based reference model.
module tb_display_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DWELL = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          we;
    logic [3:0]    wdata;
    logic          clr;
    logic [3:0]    number;
    logic          valid;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the queue holds waiting values, m_age is edges since the last pop.
    int q[$];
    int m_num;
    int m_age;
    bit m_valid;
    bit m_ovf;

    always #5 clk = ~clk;

    display_queue #(
        .DEPTH(DEPTH),
        .DWELL(DWELL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .wdata   (wdata),
        .clr     (clr),
        .number  (number),
        .valid   (valid),
        .full    (full),
        .count   (count),
        .overflow(overflow)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".number"}, int'(number), m_num);
        check({ctx, ".valid"}, int'(valid), int'(m_valid));
        check({ctx, ".count"}, int'(count), q.size());
        check({ctx, ".full"}, int'(full), int'(q.size() == DEPTH));
        check({ctx, ".overflow"}, int'(overflow), int'(m_ovf));
    endtask

    task automatic model_reset();
        q.delete();
        m_num   = 0;
        m_age   = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    function automatic bit model_pop_ready();
        return (q.size() > 0) && (!m_valid || m_age == DWELL - 1);
    endfunction

    task automatic model_step(input bit we_v, input int wd, input bit clr_v);
        bit pop;
        bit accept;
        if (clr_v) begin
            model_reset();
            return;
        end
        pop    = model_pop_ready();
        accept = we_v && (q.size() < DEPTH || pop);
        if (pop) begin
            m_num   = q.pop_front();
            m_valid = 1'b1;
            m_age   = 0;
        end else if (m_valid && m_age < DWELL - 1) begin
            m_age++;
        end
        if (accept) q.push_back(wd);
        else if (we_v) m_ovf = 1'b1;
    endtask

    task automatic cycle(input bit we_v, input logic [3:0] wd, input bit clr_v, input string ctx);
        we    = we_v;
        wdata = wd;
        clr   = clr_v;
        @(posedge clk);
        model_step(we_v, int'(wd), clr_v);
        #1;
        check_all(ctx);
    endtask

    task automatic idle(input int n, input string ctx);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, ctx);
    endtask

    initial begin
        bit ready;
        int pct;
        reset = 1'b0;
        we    = 1'b0;
        wdata = 4'h0;
        clr   = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // single write from IDLE, then a long hold
        cycle(1'b1, 4'h9, 1'b0, "single.wr");
        cycle(1'b0, 4'h0, 1'b0, "single.show");
        check("single.number9", int'(number), 9);
        idle(20, "single.hold");
        check("single.held9", int'(number), 9);

        // back-to-back writes 1,2,3
        cycle(1'b1, 4'h1, 1'b0, "b2b");
        cycle(1'b1, 4'h2, 1'b0, "b2b");
        cycle(1'b1, 4'h3, 1'b0, "b2b");
        idle(3 * DWELL, "b2b.drain");
        check("b2b.last3", int'(number), 3);

        // asynchronous reset asserted mid-cycle
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_hold");
        @(negedge clk);
        reset = 1'b1;

        // overfill: A..E queued/shown, F dropped
        for (int v = 10; v <= 15; v++) cycle(1'b1, 4'(v), 1'b0, "ovf.wr");
        check("ovf.sticky_now", int'(overflow), 1);
        idle(6 * DWELL, "ovf.drain");
        check("ovf.last_is_E", int'(number), 14);
        check("ovf.still_sticky", int'(overflow), 1);

        // full queue with a write landing on the pop edge
        cycle(1'b0, 4'h0, 1'b1, "popw.clr");
        for (int v = 1; v <= 5; v++) cycle(1'b1, 4'(v), 1'b0, "popw.fill");
        check("popw.full", int'(full), 1);
        ready = 1'b0;
        for (int i = 0; i < 4 * DWELL && !ready; i++) begin
            ready = model_pop_ready() && m_valid;
            if (!ready) cycle(1'b0, 4'h0, 1'b0, "popw.wait");
        end
        check("popw.reached", int'(ready), 1);
        cycle(1'b1, 4'h6, 1'b0, "popw.edge");
        check("popw.count4", int'(count), 4);
        check("popw.no_ovf", int'(overflow), 0);
        idle(6 * DWELL, "popw.drain");

        // clr mid-dwell with a simultaneous write
        cycle(1'b0, 4'h0, 1'b1, "clr.pre");
        for (int v = 1; v <= 4; v++) cycle(1'b1, 4'(v), 1'b0, "clr.fill");
        idle(2, "clr.mid");
        cycle(1'b1, 4'h7, 1'b1, "clr.hit");
        check("clr.number0", int'(number), 0);
        check("clr.valid0", int'(valid), 0);
        check("clr.count0", int'(count), 0);
        cycle(1'b1, 4'h5, 1'b0, "clr.wr5");
        cycle(1'b0, 4'h0, 1'b0, "clr.show5");
        check("clr.number5", int'(number), 5);
        idle(DWELL, "clr.hold");

        // randomized traffic at varying write densities, rare clears
        for (int blk = 0; blk < 8; blk++) begin
            pct = (blk % 4 == 0) ? 5 : (blk % 4 == 1) ? 30 : (blk % 4 == 2) ? 70 : 95;
            for (int i = 0; i < 100; i++) begin
                cycle(($urandom_range(0, 99) < pct), 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 149) == 0), "rand");
            end
        end
        idle(6 * DWELL, "rand.drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
